ad_capture: RTL and testbench

- Receive-side counterpart of the NCO/DAC output path. Drives the ADC sample clock and samples 8-bit ADC data at sys_clk/CLK_DIV.
- Arms on request and waits for a rising crossing of a level, with hysteresis. On trigger, stores DEPTH consecutive samples in an internal buffer.
- Streams the captured buffer out over a valid/ready interface, e.g. to a UART or display consumer. Used for on-board loopback checks of the DAC chain.

---
 rtl/ad_capture_if.sv | 20 ++
 rtl/ad_capture.sv | 177 +++++++++++++++++
 tb/tb_ad_capture.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_capture_if.sv
//------------------------------------------------------------------------------
// Module   : ad_capture_if
// Brief    : Readout stream bundle (valid/ready with last marker) of ad_capture.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ad_capture_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;

    modport master (output rd_data, output rd_valid, output rd_last, input  rd_ready);
    modport slave  (input  rd_data, input  rd_valid, input  rd_last, output rd_ready);
endinterface

`default_nettype wire

// File: rtl/ad_capture.sv
//------------------------------------------------------------------------------
// Module   : ad_capture
// Brief    : ADC clock generator, hysteresis rising-edge trigger, DEPTH-sample
//            capture buffer and zero-bubble valid/ready readout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ad_capture #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 256,
    parameter int CLK_DIV    = 4,
    parameter int TRIG_LEVEL = 128,
    parameter int HYST       = 8
) (
    input  wire               sys_clk,
    input  wire               sys_rst,
    input  wire  [DATA_W-1:0] ad_data,
    output logic              ad_clk,
    input  wire               arm,
    output logic              busy,
    output logic              triggered,
    ad_capture_if.master      rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0]     c_DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]     c_DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [DATA_W-1:0] c_LOW_TH   = DATA_W'(TRIG_LEVEL - HYST);
    localparam logic [DATA_W-1:0] c_HIGH_TH  = DATA_W'(TRIG_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOW  = 3'd1,
        S_WAIT_HIGH = 3'd2,
        S_CAPTURE   = 3'd3,
        S_READOUT   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic              ad_clk_q, ad_clk_d;
    logic [DATA_W-1:0] smp_q, smp_d;
    logic              smp_vld_q, smp_vld_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_addr_q, rd_addr_d;
    logic              ram_vld_q, ram_vld_d;
    logic              ram_last_q, ram_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              busy_q, busy_d;
    logic              triggered_q, triggered_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;

    logic              w_strobe;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_addr;
    logic              w_pop;
    logic              w_load;
    logic              w_issue;

    always_comb begin
        w_strobe  = (div_cnt_q == c_DIV_MAX);
        div_cnt_d = w_strobe ? '0 : div_cnt_q + 1'b1;
        ad_clk_d  = (div_cnt_d >= c_DIV_HALF);
        smp_d     = w_strobe ? ad_data : smp_q;
        smp_vld_d = w_strobe;

        // Two-stage prefetch: RAM output register feeds the output register,
        // so a held-high rd_ready drains one sample per cycle.
        w_pop      = rd_valid_q & rd.rd_ready;
        w_load     = ram_vld_q & (~rd_valid_q | w_pop);
        w_issue    = (state_q == S_READOUT) & ~rd_addr_q[AW] & (~ram_vld_q | w_load);
        rd_data_d  = w_load ? ram_rd_q : rd_data_q;
        rd_valid_d = w_load | (rd_valid_q & ~w_pop);
        rd_last_d  = w_load ? ram_last_q : (rd_last_q & ~w_pop);
        ram_vld_d  = w_issue | (ram_vld_q & ~w_load);
        ram_last_d = w_issue ? (rd_addr_q[AW-1:0] == {AW{1'b1}}) : ram_last_q;
        rd_addr_d  = (state_q != S_READOUT) ? '0 : rd_addr_q + {{AW{1'b0}}, w_issue};

        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        w_wr_en   = 1'b0;
        w_wr_addr = wr_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (smp_vld_q && (smp_q <= c_LOW_TH)) state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (smp_vld_q && (smp_q >= c_HIGH_TH)) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = '0;
                    wr_ptr_d  = AW'(1);
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (smp_vld_q) begin
                    w_wr_en  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == {AW{1'b1}}) state_d = S_READOUT;
                end
            end
            S_READOUT: begin
                if (w_pop && rd_last_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            ram_vld_d  = 1'b0;
        end

        busy_d      = (state_d != S_IDLE);
        triggered_d = (state_d == S_CAPTURE) || (state_d == S_READOUT);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            ad_clk_q    <= 1'b0;
            smp_q       <= '0;
            smp_vld_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_addr_q   <= '0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            ad_clk_q    <= ad_clk_d;
            smp_q       <= smp_d;
            smp_vld_q   <= smp_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_addr_q   <= rd_addr_d;
            ram_vld_q   <= ram_vld_d;
            ram_last_q  <= ram_last_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            busy_q      <= busy_d;
            triggered_q <= triggered_d;
        end
    end

    // Capture and readout never overlap, so one RAM port pair is sufficient.
    always_ff @(posedge sys_clk) begin
        if (w_wr_en) mem[w_wr_addr] <= smp_q;
        if (w_issue) ram_rd_q <= mem[rd_addr_q[AW-1:0]];
    end

    assign ad_clk      = ad_clk_q;
    assign busy        = busy_q;
    assign triggered   = triggered_q;
    assign rd.rd_data  = rd_data_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_last  = rd_last_q;

endmodule

`default_nettype wire

// File: tb/tb_ad_capture.sv
//------------------------------------------------------------------------------
// Module   : tb_ad_capture
// Brief    : Scoreboard bench for ad_capture with a sample-level trigger model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ad_capture;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;
    localparam int CLK_DIV    = 4;
    localparam int TRIG_LEVEL = 128;
    localparam int HYST       = 8;
    localparam int LOW_TH     = TRIG_LEVEL - HYST;
    localparam int LAT        = (DEPTH - 1) * CLK_DIV + 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [DATA_W-1:0] ad_data;
    logic              ad_clk;
    logic              arm;
    logic              busy;
    logic              triggered;

    ad_capture_if #(.DATA_W(DATA_W)) rd_if ();

    ad_capture #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .CLK_DIV    (CLK_DIV),
        .TRIG_LEVEL (TRIG_LEVEL),
        .HYST       (HYST)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .ad_data   (ad_data),
        .ad_clk    (ad_clk),
        .arm       (arm),
        .busy      (busy),
        .triggered (triggered),
        .rd        (rd_if)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] stim_q[$];
    int checks = 0;
    int errors = 0;
    int arm_reqs = 0, arms_issued = 0;
    int acq_started = 0, acq_done = 0;
    int phase = 0, cap = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC model plus reference: a new sample is presented on each ad_clk rise
    // and the model applies the low-then-high trigger rule to the sample stream.
    initial begin : drv
        logic       prev_clk;
        logic [7:0] v;
        prev_clk = 1'b0;
        ad_data  = '0;
        arm      = 1'b0;
        forever begin
            @(negedge sys_clk);
            arm = 1'b0;
            if (sys_rst) begin
                prev_clk    = 1'b0;
                phase       = 0;
                cap         = 0;
                acq_started = acq_done;
                arms_issued = arm_reqs;
            end else begin
                if (ad_clk && !prev_clk) begin
                    if (stim_q.size() != 0) v = stim_q.pop_front();
                    else                    v = 8'($urandom_range(0, 255));
                    ad_data = v;
                    if (arm_reqs != arms_issued) begin
                        arm = 1'b1;
                        arms_issued++;
                        if (acq_started == acq_done) begin
                            acq_started++;
                            phase = 1;
                            cap   = 0;
                        end
                    end
                    case (phase)
                        1: if (int'(v) <= LOW_TH) phase = 2;
                        2: if (int'(v) >= TRIG_LEVEL) begin
                            exp_q.push_back('{data: v, last: 1'b0});
                            cap   = 1;
                            phase = 3;
                        end
                        3: begin
                            exp_q.push_back('{data: v, last: (cap == DEPTH - 1)});
                            cap++;
                            if (cap == DEPTH) phase = 0;
                        end
                        default: ;
                    endcase
                end
                prev_clk = ad_clk;
            end
        end
    end

    // Consumer and monitor: drives rd_ready, pops the scoreboard on each transfer.
    logic [DATA_W-1:0] held_data;
    logic              held_last;
    logic              stall_prev = 1'b0, post_last = 1'b0, trig_prev = 1'b0, val_prev = 1'b0, tog = 1'b0;
    int                cyc = 0, trig_cyc = 0;

    initial begin : mon
        exp_t e;
        rd_if.rd_ready = 1'b1;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (sys_rst) begin
                exp_q.delete();
                stall_prev = 1'b0;
                post_last  = 1'b0;
                trig_prev  = 1'b0;
                val_prev   = 1'b0;
            end else begin
                case (rdy_mode)
                    0:       rd_if.rd_ready = 1'b1;
                    1:       begin tog = ~tog; rd_if.rd_ready = tog; end
                    default: rd_if.rd_ready = 1'($urandom_range(0, 1));
                endcase
                if (post_last) begin
                    check("idle_busy", int'(busy), 0);
                    check("idle_triggered", int'(triggered), 0);
                    check("idle_rd_valid", int'(rd_if.rd_valid), 0);
                    check("idle_rd_last", int'(rd_if.rd_last), 0);
                    post_last = 1'b0;
                end
                if (stall_prev) begin
                    check("hold_valid", int'(rd_if.rd_valid), 1);
                    check("hold_data", int'(rd_if.rd_data), int'(held_data));
                    check("hold_last", int'(rd_if.rd_last), int'(held_last));
                end
                if (triggered && !trig_prev) trig_cyc = cyc;
                if (rd_if.rd_valid && !val_prev) check("valid_latency", cyc - trig_cyc, LAT);
                if (rd_if.rd_valid && rd_if.rd_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %0d, expected no transfer", rd_if.rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", int'(rd_if.rd_data), int'(e.data));
                        check("rd_last", int'(rd_if.rd_last), int'(e.last));
                        if (e.last) begin
                            acq_done++;
                            post_last = 1'b1;
                        end
                    end
                end
                stall_prev = rd_if.rd_valid && !rd_if.rd_ready;
                held_data  = rd_if.rd_data;
                held_last  = rd_if.rd_last;
                trig_prev  = triggered;
                val_prev   = rd_if.rd_valid;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ad_clk"}, int'(ad_clk), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_triggered"}, int'(triggered), 0);
        check({tag, "_rd_valid"}, int'(rd_if.rd_valid), 0);
        check({tag, "_rd_last"}, int'(rd_if.rd_last), 0);
        check({tag, "_rd_data"}, int'(rd_if.rd_data), 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        for (n = 0; n < 4000; n++) begin
            @(negedge sys_clk);
            if (arm_reqs == arms_issued && acq_started == acq_done && exp_q.size() == 0) break;
        end
        checks++;
        if (n == 4000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending samples, expected 0", tag, exp_q.size());
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic push_ramp(input int from, input int to);
        for (int i = from; i <= to; i++) stim_q.push_back(8'(i));
    endtask

    task automatic acquire(input int from, input int to, input string tag);
        stim_q.delete();
        push_ramp(from, to);
        arm_reqs++;
        wait_idle(tag);
    endtask

    initial begin : main
        int n;
        // Reset and divider
        repeat (5) @(negedge sys_clk);
        check_all_zero("rst");
        sys_rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sys_clk);
            check("ad_clk_phase", int'(ad_clk), ((k % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0);
        end
        repeat (20) @(negedge sys_clk);
        check("busy_no_arm", int'(busy), 0);

        // Ramp trigger, full-rate readout
        acquire(0, 200, "ramp");

        // Backpressure 1,0,1,0
        rdy_mode = 1;
        acquire(0, 200, "bp");
        rdy_mode = 0;

        // Hovering between thresholds never triggers
        stim_q.delete();
        for (int i = 0; i < 50; i++) stim_q.push_back((i % 2) ? 8'd130 : 8'd125);
        stim_q.push_back(8'd100);
        push_ramp(140, 160);
        arm_reqs++;
        for (n = 0; n < 2000; n++) begin
            @(negedge sys_clk);
            if (stim_q.size() <= 22) break;
        end
        check("hover_busy", int'(busy), 1);
        check("hover_triggered", int'(triggered), 0);
        wait_idle("hover");

        // Arm pulses during capture and readout are ignored
        stim_q.delete();
        push_ramp(0, 200);
        arm_reqs++;
        for (n = 0; n < 2000 && !triggered; n++) @(negedge sys_clk);
        check("arm_cap_triggered", int'(triggered), 1);
        arm_reqs++;
        for (n = 0; n < 2000 && !rd_if.rd_valid; n++) @(negedge sys_clk);
        check("arm_rd_valid", int'(rd_if.rd_valid), 1);
        arm_reqs++;
        wait_idle("rearm");
        acquire(50, 200, "fresh");

        // Random data with random consumer
        rdy_mode = 2;
        for (int r = 0; r < 3; r++) begin
            stim_q.delete();
            for (int i = 0; i < 300; i++) stim_q.push_back(8'($urandom_range(0, 255)));
            push_ramp(100, 160);
            arm_reqs++;
            wait_idle("random");
        end
        rdy_mode = 0;

        // Reset mid-capture
        stim_q.delete();
        push_ramp(0, 200);
        arm_reqs++;
        for (n = 0; n < 2000; n++) begin
            @(negedge sys_clk);
            if (phase == 3 && cap == 7) break;
        end
        check("reached_cap7", cap, 7);
        sys_rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("post_rst_busy", int'(busy), 0);
        acquire(0, 200, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
